wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the dual-write-port register file.
- Merges three result sources onto the regfile's two write ports, all into the same 32-entry, x0-hardwired register space:
  - ALU lane A (older instruction of the issued pair).
  - ALU lane B (younger instruction of the issued pair).
  - Load-return lane.
- ALU lanes cannot stall, so they always get priority.
- Load returns are buffered in a small FIFO and drained into whichever write port is free.

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two ALU result lanes and a buffered load-return
// lane onto the two write ports of the register file. ALU lanes never stall
// and own their ports; loads wait in a small FIFO and take whichever port
// the ALU lanes leave idle.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LD_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_valid,
    input  logic [ADDR_WIDTH-1:0]       a_rd,
    input  logic [DATA_WIDTH-1:0]       a_data,
    input  logic                        b_valid,
    input  logic [ADDR_WIDTH-1:0]       b_rd,
    input  logic [DATA_WIDTH-1:0]       b_data,
    input  logic                        ld_valid,
    input  logic [ADDR_WIDTH-1:0]       ld_rd,
    input  logic [DATA_WIDTH-1:0]       ld_data,
    output logic                        ld_ready,
    output logic                        we_a,
    output logic [ADDR_WIDTH-1:0]       wa_a,
    output logic [DATA_WIDTH-1:0]       wd_a,
    output logic                        we_b,
    output logic [ADDR_WIDTH-1:0]       wa_b,
    output logic [DATA_WIDTH-1:0]       wd_b,
    output logic [$clog2(LD_DEPTH):0]   ld_count,
    output logic                        waw_err
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(LD_DEPTH);

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [LD_DEPTH];
    logic [PW-1:0]                    rd_ptr;
    logic [PW-1:0]                    wr_ptr;

    logic                  a_eff;
    logic                  b_eff;
    logic                  push;
    logic                  pop;
    logic                  pop_to_a;
    logic                  pop_to_b;
    logic                  waw_hit;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    // Lane qualification, port ownership and FIFO handshake decisions.
    // Pop is decided from start-of-cycle occupancy, so a load pushed this
    // cycle cannot bypass straight to a port.
    always_comb begin
        b_eff     = b_valid && (b_rd != '0);
        // Younger lane B wins a same-rd collision; A is dropped entirely.
        a_eff     = a_valid && (a_rd != '0) && !(b_eff && (a_rd == b_rd));
        {head_rd, head_data} = mem[rd_ptr];
        ld_ready  = (ld_count != FULL);
        push      = ld_valid && ld_ready && (ld_rd != '0);
        pop       = (ld_count != '0) && (!a_eff || !b_eff);
        pop_to_a  = pop && !a_eff;
        pop_to_b  = pop && a_eff;
        waw_hit   = pop && ((a_eff && (head_rd == a_rd)) ||
                            (b_eff && (head_rd == b_rd)));
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ld_rd, ld_data};
        end
    end

    // FIFO pointers, occupancy and the sticky WAW flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ld_count <= '0;
            waw_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   ld_count <= ld_count + 1'b1;
                2'b01:   ld_count <= ld_count - 1'b1;
                default: ld_count <= ld_count;
            endcase
            if (waw_hit) begin
                waw_err <= 1'b1;
            end
        end
    end

    // Registered write ports; address/data hold when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a <= 1'b0;
            wa_a <= '0;
            wd_a <= '0;
            we_b <= 1'b0;
            wa_b <= '0;
            wd_b <= '0;
        end else begin
            we_a <= a_eff || pop_to_a;
            if (a_eff) begin
                wa_a <= a_rd;
                wd_a <= a_data;
            end else if (pop_to_a) begin
                wa_a <= head_rd;
                wd_a <= head_data;
            end
            we_b <= b_eff || pop_to_b;
            if (b_eff) begin
                wa_b <= b_rd;
                wd_b <= b_data;
            end else if (pop_to_b) begin
                wa_b <= head_rd;
                wd_b <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a queue-based reference model predicts each cycle's
// port writes when stimulus is applied; predictions are popped and compared
// one cycle later, alongside directed checks on the key scenarios.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, ld_valid;
    logic [4:0]  a_rd, b_rd, ld_rd;
    logic [31:0] a_data, b_data, ld_data;
    logic        ld_ready;
    logic        we_a, we_b;
    logic [4:0]  wa_a, wa_b;
    logic [31:0] wd_a, wd_b;
    logic [2:0]  ld_count;
    logic        waw_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we_a;
        logic [4:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [4:0]  wa_b;
        logic [31:0] wd_b;
        logic [2:0]  cnt;
        logic        waw;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ld_t;

    exp_t exp_q[$];
    ld_t  mq[$];
    bit   m_waw;

    wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_ready(ld_ready),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ld_count(ld_count), .waw_err(waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus: predict, advance, then compare the prediction.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        exp_t e;
        ld_t  h;
        bit   aeff, beff, pop;
        int   size0;
        a_valid = av; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        size0 = mq.size();
        check_eq("ld_ready", ld_ready, (size0 < 4));
        beff = bv && (br != 0);
        aeff = av && (ar != 0) && !(beff && ar == br);
        e = '{default: '0};
        e.we_a = aeff; e.wa_a = ar; e.wd_a = ad;
        e.we_b = beff; e.wa_b = br; e.wd_b = bd;
        pop = (size0 != 0) && (!aeff || !beff);
        if (pop) begin
            h = mq.pop_front();
            if ((aeff && h.rd == ar) || (beff && h.rd == br)) m_waw = 1'b1;
            if (!aeff) begin
                e.we_a = 1'b1; e.wa_a = h.rd; e.wd_a = h.d;
            end else begin
                e.we_b = 1'b1; e.wa_b = h.rd; e.wd_b = h.d;
            end
        end
        if (lv && size0 < 4 && lr != 0) mq.push_back('{rd: lr, d: ldd});
        e.cnt = 3'(mq.size());
        e.waw = m_waw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("we_a", we_a, e.we_a);
        if (e.we_a) begin
            check_eq("wa_a", wa_a, e.wa_a);
            check_eq("wd_a", wd_a, e.wd_a);
        end
        check_eq("we_b", we_b, e.we_b);
        if (e.we_b) begin
            check_eq("wa_b", wa_b, e.wa_b);
            check_eq("wd_b", wd_b, e.wd_b);
        end
        check_eq("ld_count", ld_count, e.cnt);
        check_eq("waw_err", waw_err, e.waw);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit acc;
        rst_n = 1'b0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        m_waw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we_a", we_a, 0);
        check_eq("rst_we_b", we_b, 0);
        check_eq("rst_count", ld_count, 0);
        check_eq("rst_waw", waw_err, 0);
        release_reset();
        check_eq("rst_ready", ld_ready, 1);

        // 1: both lanes, distinct rd
        cycle(1, 5, 32'hDEAD, 1, 6, 32'hBEEF, 0, 0, 0);
        check_eq("t1_wa_a", wa_a, 5);
        check_eq("t1_wd_a", wd_a, 32'hDEAD);
        check_eq("t1_wa_b", wa_b, 6);
        check_eq("t1_wd_b", wd_b, 32'hBEEF);

        // 2: queue x9 under full ALU load, then same-rd collision frees port A
        cycle(1, 3, 32'h3, 1, 4, 32'h4, 1, 9, 32'h99);
        check_eq("t2_count1", ld_count, 1);
        cycle(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0);
        check_eq("t2_we_a", we_a, 1);
        check_eq("t2_wa_a", wa_a, 9);
        check_eq("t2_wd_a", wd_a, 32'h99);
        check_eq("t2_wa_b", wa_b, 7);
        check_eq("t2_wd_b", wd_b, 32'h2);
        check_eq("t2_count0", ld_count, 0);

        // 3: fill FIFO behind busy lanes, then drain in order on port A
        k = 1;
        repeat (6) begin
            acc = ld_ready;
            cycle(1, 10, 32'hA0 + k, 1, 11, 32'hB0 + k, 1, 5'(k), 32'h100 * k);
            if (acc) k++;
        end
        check_eq("t3_accepted", k, 5);
        check_eq("t3_full_cnt", ld_count, 4);
        check_eq("t3_full_rdy", ld_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check_eq("t3_drain_we", we_a, 1);
            check_eq("t3_drain_rd", wa_a, 5'(i));
            if (i == 1) check_eq("t3_rdy_after_pop", ld_ready, 1);
        end
        check_eq("t3_empty", ld_count, 0);

        // 4: no bypass, load lands two cycles after push
        cycle(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0);
        check_eq("t4_n1_we_a", we_a, 0);
        idle();
        check_eq("t4_n2_we_a", we_a, 1);
        check_eq("t4_n2_wd_a", wd_a, 32'hC0);

        // 5: x0 targets are dropped
        cycle(1, 0, 32'h55, 0, 0, 0, 1, 0, 32'h66);
        check_eq("t5_we_a", we_a, 0);
        check_eq("t5_we_b", we_b, 0);
        check_eq("t5_count", ld_count, 0);
        check_eq("t5_ready", ld_ready, 1);

        // 5b: lane B only with a pending load -> load uses port A
        cycle(0, 0, 0, 1, 13, 32'hD0, 1, 14, 32'hE0);
        cycle(0, 0, 0, 1, 15, 32'hD1, 0, 0, 0);
        check_eq("t5b_wa_a", wa_a, 14);

        // 6: WAW collision, then mid-cycle reset with 3 entries queued
        cycle(0, 0, 0, 0, 0, 0, 1, 8, 32'h88);
        cycle(1, 8, 32'h77, 0, 0, 0, 0, 0, 0);
        check_eq("t6_waw", waw_err, 1);
        check_eq("t6_wa_b", wa_b, 8);
        check_eq("t6_wd_b", wd_b, 32'h88);
        for (int i = 0; i < 3; i++)
            cycle(1, 20, 32'h20, 1, 21, 32'h21, 1, 5'(16 + i), 32'h160 + i);
        check_eq("t6_count3", ld_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_cnt", ld_count, 0);
        check_eq("t6_rst_we_a", we_a, 0);
        check_eq("t6_rst_we_b", we_b, 0);
        check_eq("t6_rst_waw", waw_err, 0);
        mq.delete();
        exp_q.delete();
        m_waw = 1'b0;
        a_valid = 0; b_valid = 0; ld_valid = 0;
        release_reset();
        idle();
        check_eq("t6_post_we_a", we_a, 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
